// File: rtl/puf_auth_pkg.sv
// Shared types and constants for the PUF challenge/response authentication controller.
package puf_auth_pkg;

  localparam int CHAL_W = 8;
  localparam int DEF_RESP_W = 8;
  localparam logic [7:0] DEF_RESP_MASK = 8'h0E;
  localparam int HD_W = 8;
  localparam int TMR_W = 20;
  localparam logic [CHAL_W-1:0] KICK_FLIP = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    ARM,
    WAIT_BUSY,
    WAIT_DONE,
    COMPARE,
    FINISH
  } state_e;

  function automatic logic [HD_W-1:0] sat_add(input logic [HD_W-1:0] a, input logic [HD_W-1:0] b);
    logic [HD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[HD_W] ? {HD_W{1'b1}} : sum[HD_W-1:0];
  endfunction

endpackage

// File: rtl/puf_hamming.sv
// Combinational masked Hamming distance between two response vectors.
module puf_hamming
  import puf_auth_pkg::*;
#(
  parameter int RESP_W = DEF_RESP_W,
  parameter int CNT_W  = $clog2(RESP_W + 1)
) (
  input  logic [RESP_W-1:0] a_i,
  input  logic [RESP_W-1:0] b_i,
  input  logic [RESP_W-1:0] mask_i,
  output logic [CNT_W-1:0]  hd_o
);

  logic [RESP_W-1:0] diff;

  always_comb begin
    diff = (a_i ^ b_i) & mask_i;
    hd_o = '0;
    for (int i = 0; i < RESP_W; i++) begin
      hd_o = hd_o + CNT_W'(diff[i]);
    end
  end

endmodule

// File: rtl/puf_auth_ctrl.sv
// Challenge-side controller for the ring-oscillator PUF: kicks, measures and scores a session.
// Optional enrollment mode (ENROLL port) is built when PUF_AUTH_ENROLL_EN is defined.
module puf_auth_ctrl
  import puf_auth_pkg::*;
#(
  parameter int                NUM_CHAL    = 8,
  parameter int                RESP_W      = DEF_RESP_W,
  parameter logic [RESP_W-1:0] RESP_MASK   = RESP_W'(DEF_RESP_MASK),
  parameter int                HD_THRESH   = 2,
  parameter int                KICK_CYC    = 4,
  parameter int                TIMEOUT_CYC = 400000
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        START,
`ifdef PUF_AUTH_ENROLL_EN
  input  logic                        ENROLL,
`endif
  input  logic                        TBL_WE,
  input  logic [$clog2(NUM_CHAL)-1:0] TBL_ADDR,
  input  logic [7:0]                  TBL_CHAL,
  input  logic [RESP_W-1:0]           TBL_RESP,
  output logic [7:0]                  PUF_CHALLENGE,
  input  logic [RESP_W-1:0]           PUF_RESPONSE,
  input  logic                        PUF_DONE,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        PASS,
  output logic                        TIMEOUT,
  output logic [7:0]                  HD_TOTAL
);

  localparam int IW = $clog2(NUM_CHAL);
  localparam int KW = $clog2(KICK_CYC + 1);
  localparam int CW = $clog2(RESP_W + 1);

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d, idx_nxt;
  logic [KW-1:0]       kick_q, kick_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [CHAL_W-1:0]   chal_q, chal_d, first_chal;
  logic [RESP_W-1:0]   resp_q, resp_d;
  logic [HD_W-1:0]     hd_total_q, hd_total_d;
  logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic                timeout_q, timeout_d, enroll_q, enroll_d;
  logic                enroll_start, host_we, enr_we, abort, timer_hit;
  logic [1:0]          sync_q;
  logic                done_s;
  logic [CW-1:0]       hd_cur;

  logic [CHAL_W-1:0]   tbl_chal_q [NUM_CHAL];
  logic [RESP_W-1:0]   tbl_resp_q [NUM_CHAL];

`ifdef PUF_AUTH_ENROLL_EN
  assign enroll_start = ENROLL;
`else
  assign enroll_start = 1'b0;
`endif

  // PUF_DONE is asynchronous to our state; idle-high reset matches a quiet PUF.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], PUF_DONE};
  end
  assign done_s = sync_q[1];

  assign host_we   = TBL_WE && !busy_q;
  assign idx_nxt   = idx_q + 1'b1;
  assign timer_hit = (timer_q == TMR_W'(TIMEOUT_CYC - 1));
  // A table write landing with START must already be visible to the first kick.
  assign first_chal = (host_we && TBL_ADDR == '0) ? TBL_CHAL : tbl_chal_q[0];

  // NOTE: table storage has no reset; it is only meaningful after enrollment writes, and
  // leaving it out of the reset tree lets it map onto plain register-file/RAM cells.
  always_ff @(posedge CLK) begin
    if (host_we) begin
      tbl_chal_q[TBL_ADDR] <= TBL_CHAL;
      tbl_resp_q[TBL_ADDR] <= TBL_RESP;
    end else if (enr_we) begin
      tbl_resp_q[idx_q] <= resp_q & RESP_MASK;
    end
  end

  puf_hamming #(.RESP_W(RESP_W)) u_hamming (
    .a_i    (resp_q),
    .b_i    (tbl_resp_q[idx_q]),
    .mask_i (RESP_MASK),
    .hd_o   (hd_cur)
  );

  // NOTE: every variable gets its hold/default value before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    kick_d     = kick_q;
    timer_d    = timer_q;
    chal_d     = chal_q;
    resp_d     = resp_q;
    hd_total_d = hd_total_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    enroll_d   = enroll_q;
    enr_we     = 1'b0;
    abort      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          idx_d      = '0;
          kick_d     = '0;
          hd_total_d = '0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          busy_d     = 1'b1;
          enroll_d   = enroll_start;
          chal_d     = first_chal ^ KICK_FLIP;
          state_d    = KICK;
        end
      end
      KICK: begin
        if (kick_q == KW'(KICK_CYC - 1)) begin
          chal_d  = tbl_chal_q[idx_q];
          state_d = ARM;
        end else begin
          kick_d = kick_q + 1'b1;
        end
      end
      ARM: begin
        timer_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        timer_d = timer_q + 1'b1;
        if (timer_hit)   abort   = 1'b1;
        else if (!done_s) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        timer_d = timer_q + 1'b1;
        if (timer_hit) begin
          abort = 1'b1;
        end else if (done_s) begin
          resp_d  = PUF_RESPONSE;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (enroll_q) enr_we     = 1'b1;
        else          hd_total_d = sat_add(hd_total_q, HD_W'(hd_cur));
        if (idx_q == IW'(NUM_CHAL - 1)) begin
          state_d = FINISH;
        end else begin
          idx_d   = idx_nxt;
          kick_d  = '0;
          chal_d  = tbl_chal_q[idx_nxt] ^ KICK_FLIP;
          state_d = KICK;
        end
      end
      FINISH: begin
        pass_d  = enroll_q ? 1'b1 : (hd_total_q <= HD_W'(HD_THRESH));
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      timeout_d = 1'b1;
      pass_d    = 1'b0;
      done_d    = 1'b1;
      busy_d    = 1'b0;
      state_d   = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together
  // from values sampled at the same edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      kick_q     <= '0;
      timer_q    <= '0;
      chal_q     <= '0;
      resp_q     <= '0;
      hd_total_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      enroll_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      kick_q     <= kick_d;
      timer_q    <= timer_d;
      chal_q     <= chal_d;
      resp_q     <= resp_d;
      hd_total_q <= hd_total_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      enroll_q   <= enroll_d;
    end
  end

  assign PUF_CHALLENGE = chal_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign PASS          = pass_q;
  assign TIMEOUT       = timeout_q;
  assign HD_TOTAL      = hd_total_q;

endmodule

// File: tb/tb_puf_auth_ctrl.sv
// Self-checking bench for puf_auth_ctrl: behavioural PUF plus session-level scoring model.
module tb_puf_auth_ctrl;

  localparam int NUM_CHAL    = 8;
  localparam int KICK_CYC    = 4;
  localparam int TIMEOUT_CYC = 300;
  localparam int MEAS_CYC    = 100;
  localparam logic [7:0] MASK = 8'h0E;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       tbl_we = 1'b0;
  logic [2:0] tbl_addr = '0;
  logic [7:0] tbl_chal = '0;
  logic [7:0] tbl_resp = '0;
  logic [7:0] puf_challenge;
  logic [7:0] puf_response = '0;
  logic       puf_done = 1'b1;
  logic       busy, done, pass, timeout;
  logic [7:0] hd_total;
`ifdef PUF_AUTH_ENROLL_EN
  logic       enroll = 1'b0;
`endif

  always #5 clk = ~clk;

  puf_auth_ctrl #(
    .NUM_CHAL    (NUM_CHAL),
    .RESP_W      (8),
    .RESP_MASK   (MASK),
    .HD_THRESH   (2),
    .KICK_CYC    (KICK_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .CLK           (clk),
    .RST_N         (rst_n),
    .START         (start),
`ifdef PUF_AUTH_ENROLL_EN
    .ENROLL        (enroll),
`endif
    .TBL_WE        (tbl_we),
    .TBL_ADDR      (tbl_addr),
    .TBL_CHAL      (tbl_chal),
    .TBL_RESP      (tbl_resp),
    .PUF_CHALLENGE (puf_challenge),
    .PUF_RESPONSE  (puf_response),
    .PUF_DONE      (puf_done),
    .BUSY          (busy),
    .DONE          (done),
    .PASS          (pass),
    .TIMEOUT       (timeout),
    .HD_TOTAL      (hd_total)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Enrolled pairs; t_err is what the simulated PUF gets wrong on each challenge.
  logic [7:0] t_chal [NUM_CHAL] = '{8'h03, 8'h05, 8'h1A, 8'h27, 8'h30, 8'h4C, 8'h55, 8'h6F};
  logic [7:0] t_resp [NUM_CHAL] = '{8'h5A, 8'hC3, 8'h0F, 8'h96, 8'h71, 8'hE8, 8'h2D, 8'hB4};
  logic [7:0] t_err  [NUM_CHAL] = '{default: 8'h00};
  bit         hang = 1'b0;

  function automatic logic [7:0] puf_lookup(input logic [7:0] c);
    for (int k = 0; k < NUM_CHAL; k++)
      if (t_chal[k] == c) return t_resp[k] ^ t_err[k];
    return 8'h00;
  endfunction

  // PUF: any parity change of the challenge restarts a MEAS_CYC-long measurement.
  int   meas_cnt = 0;
  logic last_par = 1'b0;
  always @(negedge clk) begin
    if (hang) begin
      puf_done = 1'b1;
      meas_cnt = 0;
    end else if ((^puf_challenge) != last_par) begin
      meas_cnt = MEAS_CYC;
      puf_done = 1'b0;
    end else if (meas_cnt > 0) begin
      meas_cnt = meas_cnt - 1;
      if (meas_cnt == 0) begin
        puf_response = puf_lookup(puf_challenge);
        puf_done     = 1'b1;
      end
    end
    last_par = ^puf_challenge;
  end

  function automatic int model_hd();
    int s = 0;
    for (int k = 0; k < NUM_CHAL; k++) s += $countones(t_err[k] & MASK);
    return (s > 255) ? 255 : s;
  endfunction

  bit         exp_to = 1'b0;
  int         exp_hd = 0;
  bit         exp_pass = 1'b0;

  int         cyc = 0, start_cyc = 0, last_lat = 0, done_cnt = 0;
  logic       prev_busy = 1'b0, prev_done = 1'b0;
  logic [7:0] last_hd = '0;
  logic       last_pass = 1'b0, last_to = 1'b0;
  logic [7:0] run_val [$];
  int         run_len [$];

  task automatic check_trace();
    check("trace_run_count", run_val.size(), 2 * NUM_CHAL);
    if (run_val.size() == 2 * NUM_CHAL) begin
      for (int k = 0; k < NUM_CHAL; k++) begin
        check($sformatf("trace_kick_val[%0d]", k), run_val[2*k], t_chal[k] ^ 8'h01);
        check($sformatf("trace_kick_len[%0d]", k), run_len[2*k], KICK_CYC);
        check($sformatf("trace_arm_val[%0d]", k), run_val[2*k+1], t_chal[k]);
      end
    end
  endtask

  // Compare process: traces the challenge while busy and scores every session end.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst_n) begin
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_pulse_width", done, 1'b0);
      if (busy && !prev_busy) begin
        start_cyc = cyc;
        run_val.delete();
        run_len.delete();
      end
      if (busy) begin
        if (run_val.size() == 0 || run_val[run_val.size()-1] != puf_challenge) begin
          run_val.push_back(puf_challenge);
          run_len.push_back(1);
        end else begin
          run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
        end
      end
      if (done) begin
        done_cnt++;
        last_lat  = cyc - start_cyc;
        last_hd   = hd_total;
        last_pass = pass;
        last_to   = timeout;
        check("end_busy", busy, 1'b0);
        check("end_hd_total", hd_total, exp_hd);
        check("end_pass", pass, exp_pass);
        check("end_timeout", timeout, exp_to);
        if (!exp_to) check_trace();
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  task automatic set_expect(input bit to);
    exp_to   = to;
    exp_hd   = to ? 0 : model_hd();
    exp_pass = !to && (exp_hd <= 2);
  endtask

  task automatic run_session(input bit to, input bit poke, input bit we_with_start);
    int d0;
    set_expect(to);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    if (we_with_start) begin
      tbl_we   = 1'b1;
      tbl_addr = 3'd0;
      tbl_chal = t_chal[0];
      tbl_resp = t_resp[0];
    end
    @(negedge clk);
    start  = 1'b0;
    tbl_we = 1'b0;
    if (poke) begin
      repeat (200) @(negedge clk);
      start    = 1'b1;
      tbl_we   = 1'b1;
      tbl_addr = 3'd2;
      tbl_chal = 8'hEE;
      tbl_resp = 8'h11;
      @(negedge clk);
      start  = 1'b0;
      tbl_we = 1'b0;
    end
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
    check("session_done_seen", done_cnt - d0, 1);
    repeat (3) @(negedge clk);
    check("pass_held", pass, exp_pass);
    check("timeout_held", timeout, to);
    check("hd_total_held", hd_total, exp_hd);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_pass"}, pass, 1'b0);
    check({tag, "_timeout"}, timeout, 1'b0);
    check({tag, "_hd_total"}, hd_total, 8'h00);
    check({tag, "_challenge"}, puf_challenge, 8'h00);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Entry 0 gets a stale challenge; the real one is written alongside START.
    for (int k = 0; k < NUM_CHAL; k++) begin
      tbl_we   = 1'b1;
      tbl_addr = 3'(k);
      tbl_chal = (k == 0) ? 8'hAA : t_chal[k];
      tbl_resp = t_resp[k];
      @(negedge clk);
    end
    tbl_we = 1'b0;

    // Exact responses; also the 03/05 challenge waveform.
    run_session(1'b0, 1'b0, 1'b1);
    check("t1_hd", last_hd, 8'd0);
    check("t1_pass", last_pass, 1'b1);
    check("t1_timeout", last_to, 1'b0);
    if (run_val.size() >= 4) begin
      check("t5_kick0_val", run_val[0], 8'h02);
      check("t5_kick0_len", run_len[0], 4);
      check("t5_arm0_val", run_val[1], 8'h03);
      check("t5_kick1_val", run_val[2], 8'h04);
      check("t5_kick1_len", run_len[2], 4);
      check("t5_arm1_val", run_val[3], 8'h05);
    end else begin
      check("t5_run_count", run_val.size(), 16);
    end

    // Bit 1 wrong on two challenges, with START and TBL_WE poked mid-session.
    t_err[1] = 8'h02;
    t_err[4] = 8'h02;
    run_session(1'b0, 1'b1, 1'b0);
    check("t2a_hd", last_hd, 8'd2);
    check("t2a_pass", last_pass, 1'b1);

    t_err[6] = 8'h02;
    run_session(1'b0, 1'b0, 1'b0);
    check("t2b_hd", last_hd, 8'd3);
    check("t2b_pass", last_pass, 1'b0);

    // Only unmasked bits differ.
    for (int k = 0; k < NUM_CHAL; k++) t_err[k] = 8'hF1;
    run_session(1'b0, 1'b0, 1'b0);
    check("t3_hd", last_hd, 8'd0);
    check("t3_pass", last_pass, 1'b1);

    // Every informative bit wrong.
    for (int k = 0; k < NUM_CHAL; k++) t_err[k] = 8'h0E;
    run_session(1'b0, 1'b0, 1'b0);
    check("all_wrong_hd", last_hd, 8'd24);
    check("all_wrong_pass", last_pass, 1'b0);

    // PUF never goes busy: timeout KICK_CYC + 1 + TIMEOUT_CYC cycles after START.
    hang = 1'b1;
    run_session(1'b1, 1'b0, 1'b0);
    check("t4_timeout", last_to, 1'b1);
    check("t4_pass", last_pass, 1'b0);
    check("t4_latency", last_lat, 305);
    hang = 1'b0;

    // Asynchronous reset during WAIT_DONE of idx 3.
    for (int k = 0; k < NUM_CHAL; k++) t_err[k] = 8'h00;
    t_err[0] = 8'h06;
    set_expect(1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000 && !(busy && puf_challenge == t_chal[3]); i++) @(negedge clk);
    check("t6_reach_idx3", puf_challenge, t_chal[3]);
    repeat (50) @(negedge clk);
    check("t6_pre_reset_hd", hd_total, 8'd2);
    check("t6_pre_reset_busy", busy, 1'b1);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_async");
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_no_done", done_cnt - d0, 0);
    run_session(1'b0, 1'b0, 1'b0);
    check("t6_restart_hd", last_hd, 8'd2);
    check("t6_restart_pass", last_pass, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
